ft_sync_tx: RTL and testbench
=============================

FT_SYNC_TX -- requirements
Module: ft_sync_tx

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning internal byte FIFO holds 2^DEPTH_LOG2 entries.
REQ-002 SHALL have parameter TURN_CYCLES, default 1, meaning idle bus cycles between taking ft_d and first WR# assertion.
REQ-003 SHALL have port ft_clk  input  1  the 60 MHz FT232H CLKOUT; the single clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  8  byte to send to host.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a byte; transfer occurs when in_valid && in_ready.
REQ-008 SHALL have port bus_grant  input  1  bus arbiter allows TX to own ft_d (receiver is idle, ft_oe high).
REQ-009 SHALL have port bus_req  output  1  TX wants the bus.
REQ-010 SHALL have port ft_txe  input  1  FT232H TXE#, active low, host buffer has space.
REQ-011 SHALL have port ft_wr  output  1  FT232H WR#, active low.
REQ-012 SHALL have port ft_d_out  output  8  data to drive onto ft_d.
REQ-013 SHALL have port ft_d_oe  output  1  tristate enable for ft_d in the top level.
REQ-014 SHALL have port tx_count  output  16  count of bytes accepted by FT232H, wraps modulo 2^16.

Function
REQ-015 FIFO SHALL be synchronous first-word-fall-through; in_ready = not full; push on in_valid && in_ready.
REQ-016 FSM states SHALL be IDLE, TURN, WRITE, RELEASE.
REQ-017 IDLE: bus_req=0, ft_d_oe=0, ft_wr=1; go TURN when FIFO non-empty and ft_txe==0 and bus_grant==1.
REQ-018 bus_req SHALL be 1 whenever FIFO non-empty and state is IDLE, TURN or WRITE.
REQ-019 TURN: ft_d_oe=1, ft_wr=1, ft_d_out=FIFO head; stay TURN_CYCLES cycles then WRITE; if bus_grant drops go RELEASE.
REQ-020 WRITE: ft_d_oe=1, ft_d_out=FIFO head, ft_wr=0 registered.
REQ-021 A byte SHALL be accepted at a rising edge only when registered ft_wr==0 and sampled ft_txe==0 at that same edge; only then pop FIFO and increment tx_count.
REQ-022 If ft_txe==1 at an edge with ft_wr==0, the byte SHALL NOT be popped; ft_d_out holds the same byte, ft_wr deasserts next cycle, FSM goes RELEASE.
REQ-023 WRITE continues back-to-back, one byte per cycle, while FIFO non-empty, ft_txe==0 and bus_grant==1.
REQ-024 FIFO empty after a pop, or bus_grant==0, SHALL send WRITE to RELEASE with ft_wr=1 next cycle.
REQ-025 RELEASE: ft_wr=1, ft_d_oe=1 for exactly one cycle, then IDLE with ft_d_oe=0.
REQ-026 ft_wr and ft_d_oe SHALL be flop outputs; ft_wr==0 SHALL imply ft_d_oe==1.
REQ-027 Simultaneous push and pop SHALL both occur, even when full (pop frees slot same edge) or empty-with-FWFT is not possible (pop requires non-empty).
REQ-028 Pointers SHALL be DEPTH_LOG2+1 bits, wrap naturally; full/empty from MSB compare.

Reset
REQ-029 On reset: state IDLE, FIFO empty, in_ready=1 after release, bus_req=0, ft_wr=1, ft_d_oe=0, ft_d_out=0, tx_count=0.
REQ-030 Reset mid-WRITE SHALL drive ft_wr=1 and ft_d_oe=0 asynchronously; queued bytes are discarded.

Structure
REQ-031 State encoding and FT signal polarity constants SHALL live in shared package ft_pkg, also used by the receive block.
REQ-032 FIFO SHALL be a sub-module ft_fifo_sync (parameter DEPTH_LOG2, width 8), reusable by the receive path.

Verification
REQ-033 Push 0x11,0x22,0x33, ft_txe=0, bus_grant=1 -> ft_d_oe rises, one TURN cycle, three consecutive WR# low cycles carrying 0x11,0x22,0x33, tx_count=3, then RELEASE, IDLE.
REQ-034 Push 8 bytes, ft_txe goes 1 while 4th byte on bus -> 4th not popped, WR# deasserts, after ft_txe=0 resend starts with 4th byte, all 8 received once, tx_count=8.
REQ-035 Push 16 bytes with ft_txe=1 -> in_ready=0 after 16th, no WR#; set ft_txe=0 -> 16 bytes in order, in_ready returns 1 after first pop.
REQ-036 Drop bus_grant during WRITE after 2 of 5 bytes -> RELEASE, ft_d_oe=0 next, resume sends bytes 3-5 on re-grant.
REQ-037 Assert reset during WRITE -> ft_wr=1, ft_d_oe=0 immediately, tx_count=0, FIFO empty.
REQ-038 Send 65537 bytes -> tx_count wraps to 1.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared FT232H synchronous-FIFO definitions for the transmit and receive blocks.
package ft_pkg;

  // Transmit-side bus ownership states
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StTurn    = 2'd1,
    StWrite   = 2'd2,
    StRelease = 2'd3
  } ft_state_e;

  // FT232H strobe polarities (WR#, TXE#, RD#, RXF# are all active low)
  localparam logic FtWrOn     = 1'b0;
  localparam logic FtWrOff    = 1'b1;
  localparam logic FtTxeSpace = 1'b0;

  localparam int unsigned FtDataW = 8;

endpackage

// File: rtl/ft_fifo_sync.sv
// Single-clock first-word-fall-through FIFO with extra-MSB wrap pointers.
module ft_fifo_sync #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [DEPTH_LOG2:0] wptr_q, rptr_q;
  logic [WIDTH-1:0]    mem_q [Depth];
  logic                do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                   (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[DEPTH_LOG2-1:0]];

  // A pop on a full FIFO frees the slot the same-edge push lands in
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer update; reset empties the FIFO without touching storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ft_sync_tx.sv
// FT232H synchronous-FIFO transmit path: byte FIFO plus WR# bus sequencer.
module ft_sync_tx
  import ft_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned TURN_CYCLES = 1  // must be >= 1
) (
  input  logic         ft_clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         bus_grant,
  output logic         bus_req,
  input  logic         ft_txe,
  output logic         ft_wr,
  output logic [7:0]   ft_d_out,
  output logic         ft_d_oe,
  output logic [15:0]  tx_count
);

  localparam int unsigned TurnW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam logic [DEPTH_LOG2:0] CntOne = 1;

  ft_state_e           state_q;
  logic                wr_q, oe_q;
  logic [TurnW-1:0]    turn_q;
  logic [15:0]         cnt_q;

  logic                fifo_full, fifo_empty, push, accept, last, turn_done;
  logic [7:0]          fifo_head;
  logic [DEPTH_LOG2:0] fifo_count;
  int unsigned         turn_elapsed;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  // WR# is only low in StWrite, so this is the FT232H's own accept condition
  assign accept   = (wr_q == FtWrOn) && (ft_txe == FtTxeSpace);
  // The accepted byte was the only one and nothing refills the FIFO this edge
  assign last     = (fifo_count == CntOne) && !push;

  assign turn_elapsed = 32'(turn_q) + 32'd1;
  assign turn_done    = (turn_elapsed >= TURN_CYCLES);

  ft_fifo_sync #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (FtDataW)
  ) u_fifo (
    .clk_i   (ft_clk),
    .rst_i   (reset),
    .push_i  (push),
    .wdata_i (in_data),
    .pop_i   (accept),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Bus sequencer with registered WR#/OE and accepted-byte counter
  always_ff @(posedge ft_clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wr_q    <= FtWrOff;
      oe_q    <= 1'b0;
      turn_q  <= '0;
      cnt_q   <= '0;
    end else begin
      if (accept) cnt_q <= cnt_q + 16'd1;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty && (ft_txe == FtTxeSpace) && bus_grant) begin
            state_q <= StTurn;
            oe_q    <= 1'b1;
            turn_q  <= '0;
          end
        end
        StTurn: begin
          if (!bus_grant) begin
            state_q <= StRelease;
          end else if (turn_done) begin
            state_q <= StWrite;
            wr_q    <= FtWrOn;
          end else begin
            turn_q <= turn_q + 1'b1;
          end
        end
        StWrite: begin
          // A refused byte stays at the FIFO head for the next bus tenure
          if (!accept || last || !bus_grant) begin
            state_q <= StRelease;
            wr_q    <= FtWrOff;
          end
        end
        StRelease: begin
          state_q <= StIdle;
          oe_q    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          wr_q    <= FtWrOff;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ft_wr    = wr_q;
  assign ft_d_oe  = oe_q;
  assign ft_d_out = oe_q ? fifo_head : 8'h00;
  assign bus_req  = !fifo_empty && (state_q != StRelease);
  assign tx_count = cnt_q;

endmodule

// File: tb/tb_ft_sync_tx.sv
// Self-checking bench for ft_sync_tx: directed scenarios plus random traffic,
// checked against a host/FIFO model built from queues.
module tb_ft_sync_tx;

  logic        ft_clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        bus_grant;
  logic        bus_req;
  logic        ft_txe;
  logic        ft_wr;
  logic [7:0]  ft_d_out;
  logic        ft_d_oe;
  logic [15:0] tx_count;

  ft_sync_tx #(
    .DEPTH_LOG2  (4),
    .TURN_CYCLES (1)
  ) dut (
    .ft_clk    (ft_clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bus_grant (bus_grant),
    .bus_req   (bus_req),
    .ft_txe    (ft_txe),
    .ft_wr     (ft_wr),
    .ft_d_out  (ft_d_out),
    .ft_d_oe   (ft_d_oe),
    .tx_count  (tx_count)
  );

  always #5 ft_clk = ~ft_clk;

  // Model: bytes written but not yet taken by the host, and bytes taken
  logic [7:0]  exp_q [$];
  int          acc_cnt = 0;
  int          checks  = 0;
  int          errors  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predict the coming rising edge, advance to the next falling edge, check.
  task automatic step();
    if (ft_wr === 1'b0 && ft_txe === 1'b0) begin
      chk("host_has_byte", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("host_byte", ft_d_out, exp_q.pop_front());
        acc_cnt++;
      end
    end
    if (in_valid && in_ready) exp_q.push_back(in_data);
    @(negedge ft_clk);
    chk("tx_count", tx_count, acc_cnt[15:0]);
    chk("in_ready", in_ready, 32'(exp_q.size() < 16));
    if (ft_wr === 1'b0) chk("wr_implies_oe", ft_d_oe, 1);
    if (ft_d_oe === 1'b0) chk("idle_bus_req", bus_req, 32'(exp_q.size() != 0));
  endtask

  task automatic push_byte(input logic [7:0] d);
    logic hs;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200; i++) begin
      hs = in_ready;
      step();
      if (hs) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_acc(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && acc_cnt < target; i++) step();
    chk(tag, tx_count, target[15:0]);
  endtask

  initial begin
    logic [7:0] bytes8 [8];
    logic       exp_oe [6];
    logic       exp_wr [6];
    logic [7:0] exp_d  [6];
    int         base;
    int         pushes;
    logic       hs;

    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; bus_grant = 1'b0; ft_txe = 1'b1;
    repeat (3) @(negedge ft_clk);
    chk("rst_wr", ft_wr, 1);
    chk("rst_oe", ft_d_oe, 0);
    chk("rst_dout", ft_d_out, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_tx_count", tx_count, 0);
    reset = 1'b0;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    // Three bytes, one turn cycle, three back-to-back writes, release, idle
    ft_txe = 1'b0;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    chk("s1_bus_req_waiting", bus_req, 1);
    chk("s1_oe_waiting", ft_d_oe, 0);
    exp_oe = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_wr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_d  = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
    bus_grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("s1_oe_%0d", i), ft_d_oe, exp_oe[i]);
      chk($sformatf("s1_wr_%0d", i), ft_wr, exp_wr[i]);
      if (exp_wr[i] == 1'b0) chk($sformatf("s1_data_%0d", i), ft_d_out, exp_d[i]);
    end
    chk("s1_tx_count", tx_count, 3);

    // Host buffer fills while the 4th byte is on the bus
    bus_grant = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 8; i++) begin
      bytes8[i] = 8'($urandom);
      push_byte(bytes8[i]);
    end
    bus_grant = 1'b1;
    for (int i = 0; i < 40 && acc_cnt < base + 3; i++) step();
    chk("s2_fourth_on_bus", ft_d_out, bytes8[3]);
    chk("s2_wr_low", ft_wr, 0);
    ft_txe = 1'b1;
    step();
    chk("s2_wr_released", ft_wr, 1);
    chk("s2_hold_byte", ft_d_out, bytes8[3]);
    repeat (4) step();
    chk("s2_idle_oe", ft_d_oe, 0);
    ft_txe = 1'b0;
    wait_acc("s2_total", base + 8, 60);

    // Fill the FIFO while the host has no room, then drain in order
    ft_txe = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    chk("s3_full", in_ready, 0);
    chk("s3_no_wr", ft_wr, 1);
    ft_txe = 1'b0;
    wait_acc("s3_total", base + 16, 80);

    // Grant withdrawn as the 2nd of 5 bytes is taken
    bus_grant = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 5; i++) push_byte(8'($urandom));
    bus_grant = 1'b1;
    for (int i = 0; i < 40 && acc_cnt < base + 1; i++) step();
    chk("s4_second_on_bus", ft_wr, 0);
    bus_grant = 1'b0;
    step();
    chk("s4_release_wr", ft_wr, 1);
    chk("s4_release_oe", ft_d_oe, 1);
    chk("s4_after_two", tx_count, 16'(base + 2));
    step();
    chk("s4_oe_off", ft_d_oe, 0);
    repeat (3) step();
    bus_grant = 1'b1;
    wait_acc("s4_total", base + 5, 60);

    // Random traffic, back-pressure and arbitration
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      ft_txe    = ($urandom_range(0, 3) == 0);
      bus_grant = ($urandom_range(0, 7) != 0);
      step();
    end
    in_valid = 1'b0; ft_txe = 1'b0; bus_grant = 1'b1;
    wait_acc("rand_drain", acc_cnt + exp_q.size(), 200);

    // Reset in the middle of a write burst
    bus_grant = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 6; i++) push_byte(8'($urandom));
    bus_grant = 1'b1;
    for (int i = 0; i < 40 && acc_cnt < base + 2; i++) step();
    chk("s5_in_write", ft_wr, 0);
    #2 reset = 1'b1;
    #1;
    chk("s5_async_wr", ft_wr, 1);
    chk("s5_async_oe", ft_d_oe, 0);
    exp_q.delete();
    acc_cnt = 0;
    @(negedge ft_clk);
    chk("s5_tx_count", tx_count, 0);
    chk("s5_bus_req", bus_req, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s5_no_write", ft_wr, 1);
    end

    // Stream 65537 bytes so the counter wraps
    pushes = 0;
    for (int i = 0; i < 70000 && pushes < 65537; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      hs = in_ready;
      step();
      if (hs) pushes++;
    end
    in_valid = 1'b0;
    wait_acc("wrap_count", 65537, 100);
    chk("wrap_is_one", tx_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
